// File: rtl/lsu_bridge_pkg.sv
// Shared definitions for the load/store bridge: funct3 encodings, FSM state codes
// and the request legality helpers.
package lsu_bridge_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        LSU_ST_IDLE,
        LSU_ST_RD,
        LSU_ST_RD_WAIT,
        LSU_ST_WR,
        LSU_ST_RESP
    } lsu_state_e;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return f3 inside {F3_SB, F3_SH, F3_SW};
        else
            return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    endfunction

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] offset);
        case (f3[1:0])
            2'b01:   return offset[0];
            2'b10:   return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_bridge_align.sv
// Little-endian lane handling: extracts and extends load data, and merges
// sub-word store data into the previously read word.
module lsu_bridge_align
    import lsu_bridge_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [4:0]         shamt;
    logic [31:0]        shifted;
    logic [31:0]        mask;
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;

    assign shamt   = {offset, 3'b000};
    assign shifted = word >> shamt;
    assign lane_b  = $signed(shifted[7:0]);
    assign lane_h  = $signed(shifted[15:0]);

    always_comb begin
        load_data = word;
        case (funct3)
            F3_LB:   load_data = 32'(lane_b);
            F3_LH:   load_data = 32'(lane_h);
            F3_LBU:  load_data = {24'h0, shifted[7:0]};
            F3_LHU:  load_data = {16'h0, shifted[15:0]};
            default: load_data = word;
        endcase
    end

    always_comb begin
        mask = 32'hFFFF_FFFF;
        case (funct3)
            F3_SB:   mask = 32'h0000_00FF << shamt;
            F3_SH:   mask = 32'h0000_FFFF << shamt;
            default: mask = 32'hFFFF_FFFF;
        endcase
        store_word = (word & ~mask) | ((wdata << shamt) & mask);
    end

endmodule

// File: rtl/lsu_bridge.sv
// Load/store bridge between the core data port and a word-only memory; sub-word
// stores are done as read-modify-write, illegal/misaligned requests answer with an error.
module lsu_bridge
    import lsu_bridge_pkg::*;
#(
    parameter int MEM_RD_LAT = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_r_en,
    output logic [31:0] mem_r_addr,
    input  logic [31:0] mem_r_data,
    output logic        mem_w_en,
    output logic [31:0] mem_w_addr,
    output logic [31:0] mem_w_data
);

    localparam int CNT_W = $clog2(MEM_RD_LAT + 1);
    // RD_WAIT lasts MEM_RD_LAT-1 cycles; the counter holds the cycles left after the current one.
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((MEM_RD_LAT > 1) ? MEM_RD_LAT - 2 : 0);

    lsu_state_e       state, state_next;
    logic             we_q, err_q;
    logic [2:0]       f3_q;
    logic [31:0]      addr_q, wdata_q, word_q;
    logic [CNT_W-1:0] cnt;
    logic             accept, req_bad, rd_done;
    logic [31:0]      load_data, store_word;

    assign accept  = req_valid && (state == LSU_ST_IDLE);
    assign req_bad = !f3_legal(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
    assign rd_done = ((state == LSU_ST_RD) && (MEM_RD_LAT == 1)) ||
                     ((state == LSU_ST_RD_WAIT) && (cnt == '0));

    lsu_bridge_align u_align (
        .word       (word_q),
        .offset     (addr_q[1:0]),
        .funct3     (f3_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= LSU_ST_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            cnt     <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                err_q   <= req_bad;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (rd_done)
                word_q <= mem_r_data;
            if (state == LSU_ST_RD)
                cnt <= WAIT_INIT;
            else if ((state == LSU_ST_RD_WAIT) && (cnt != '0))
                cnt <= cnt - CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_r_en   = 1'b0;
        mem_r_addr = '0;
        mem_w_en   = 1'b0;
        mem_w_addr = '0;
        mem_w_data = '0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        case (state)
            LSU_ST_IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (req_bad)
                        state_next = LSU_ST_RESP;
                    else if (req_we && (req_funct3 == F3_SW))
                        state_next = LSU_ST_WR;
                    else
                        state_next = LSU_ST_RD;
                end
            end
            LSU_ST_RD: begin
                mem_r_en   = 1'b1;
                mem_r_addr = {addr_q[31:2], 2'b00};
                if (MEM_RD_LAT == 1)
                    state_next = we_q ? LSU_ST_WR : LSU_ST_RESP;
                else
                    state_next = LSU_ST_RD_WAIT;
            end
            LSU_ST_RD_WAIT: begin
                if (cnt == '0)
                    state_next = we_q ? LSU_ST_WR : LSU_ST_RESP;
            end
            LSU_ST_WR: begin
                mem_w_en   = 1'b1;
                mem_w_addr = {addr_q[31:2], 2'b00};
                mem_w_data = (f3_q == F3_SW) ? wdata_q : store_word;
                state_next = LSU_ST_RESP;
            end
            LSU_ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (err_q || we_q) ? 32'h0 : load_data;
                state_next = LSU_ST_IDLE;
            end
            default: state_next = LSU_ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_bridge.sv
// Bench for lsu_bridge: two instances (read latency 1 and 3) against a shared word
// memory, a transaction-level reference model checked every cycle, and directed vectors.
module tb_lsu_bridge;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        sel = 1'b0;

    logic [1:0]  vin;
    logic [1:0]  ready, ren, wen, rvalid, rerr;
    logic [31:0] raddr [2];
    logic [31:0] waddr [2];
    logic [31:0] wdat  [2];
    logic [31:0] rdat  [2];
    logic [31:0] mrd   [2];

    int checks = 0;
    int errors = 0;

    assign vin[0] = req_valid & ~sel;
    assign vin[1] = req_valid & sel;

    lsu_bridge #(.MEM_RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(vin[0]), .req_ready(ready[0]), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rvalid[0]), .resp_rdata(rdat[0]), .resp_err(rerr[0]),
        .mem_r_en(ren[0]), .mem_r_addr(raddr[0]), .mem_r_data(mrd[0]),
        .mem_w_en(wen[0]), .mem_w_addr(waddr[0]), .mem_w_data(wdat[0])
    );

    lsu_bridge #(.MEM_RD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .req_valid(vin[1]), .req_ready(ready[1]), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rvalid[1]), .resp_rdata(rdat[1]), .resp_err(rerr[1]),
        .mem_r_en(ren[1]), .mem_r_addr(raddr[1]), .mem_r_data(mrd[1]),
        .mem_w_en(wen[1]), .mem_w_addr(waddr[1]), .mem_w_data(wdat[1])
    );

    // Word memory; read data is only valid exactly MEM_RD_LAT-1 cycles after the enable.
    logic [31:0] mem [0:255];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_idx = '0;
    logic [31:0] poke_val = '0;
    logic [1:0]  v3 = '0;
    logic [31:0] hold3 = '0;

    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        if (wen[0])  mem[waddr[0][9:2]] <= wdat[0];
        if (wen[1])  mem[waddr[1][9:2]] <= wdat[1];
        v3 <= {v3[0], ren[1]};
        if (ren[1]) hold3 <= raddr[1];
    end

    assign mrd[0] = ren[0] ? mem[raddr[0][9:2]] : 32'hBAD0_0BAD;
    assign mrd[1] = v3[1]  ? mem[hold3[9:2]]    : 32'hBAD0_0BAD;

    // Reference model: request legality, response cycle and result from the access rules.
    function automatic bit illegal(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = int'(f3[1:0]);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (we && f3[2]) return 1'b1;
        if (sz == 1 && a[0]) return 1'b1;
        if (sz == 2 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int resp_at(input int lat, input bit we, input logic [2:0] f3, input logic [31:0] a);
        if (illegal(we, f3, a)) return 1;
        if (!we) return 1 + lat;
        if (f3 == 3'd2) return 2;
        return 2 + lat;
    endfunction

    function automatic int write_at(input int lat, input logic [2:0] f3);
        return (f3 == 3'd2) ? 1 : 1 + lat;
    endfunction

    function automatic logic [31:0] size_mask(input logic [2:0] f3);
        int bits;
        bits = 8 << f3[1:0];
        return (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v, m;
        int bits, off;
        off  = int'(a[1:0]);
        bits = 8 << f3[1:0];
        m    = size_mask(f3);
        v    = (w >> (8 * off)) & m;
        if (!f3[2] && bits < 32 && v[bits-1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] m;
        int off;
        off = int'(a[1:0]);
        m   = size_mask(f3) << (8 * off);
        return (old & ~m) | ((wd << (8 * off)) & m);
    endfunction

    bit          m_busy [2] = '{1'b0, 1'b0};
    int          m_n    [2] = '{0, 0};
    bit          m_we   [2];
    logic [2:0]  m_f3   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd   [2];
    logic [31:0] m_old  [2];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_busy[i] <= 1'b0;
                m_n[i]    <= 0;
            end else if (m_busy[i]) begin
                if (m_n[i] == resp_at(lat_of(i), m_we[i], m_f3[i], m_addr[i]))
                    m_busy[i] <= 1'b0;
                else
                    m_n[i] <= m_n[i] + 1;
            end else if (vin[i]) begin
                m_busy[i] <= 1'b1;
                m_n[i]    <= 1;
                m_we[i]   <= req_we;
                m_f3[i]   <= req_funct3;
                m_addr[i] <= req_addr;
                m_wd[i]   <= req_wdata;
                m_old[i]  <= mem[req_addr[9:2]];
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit          ill, e_rdy, e_ren, e_wen, e_rv, e_err, bad;
            logic [31:0] e_rdata, e_waddr, e_wdata;
            ill     = m_busy[i] && illegal(m_we[i], m_f3[i], m_addr[i]);
            e_rdy   = !m_busy[i];
            e_ren   = m_busy[i] && !ill && (!m_we[i] || m_f3[i] != 3'd2) && m_n[i] == 1;
            e_wen   = m_busy[i] && !ill && m_we[i] && m_n[i] == write_at(lat_of(i), m_f3[i]);
            e_rv    = m_busy[i] && m_n[i] == resp_at(lat_of(i), m_we[i], m_f3[i], m_addr[i]);
            e_err   = e_rv && ill;
            e_rdata = (e_rv && !ill && !m_we[i]) ? load_val(m_old[i], m_f3[i], m_addr[i]) : 32'h0;
            e_waddr = {m_addr[i][31:2], 2'b00};
            e_wdata = (m_f3[i] == 3'd2) ? m_wd[i] : merge(m_old[i], m_wd[i], m_f3[i], m_addr[i]);
            bad = (ready[i] !== e_rdy) || (ren[i] !== e_ren) || (wen[i] !== e_wen) ||
                  (rvalid[i] !== e_rv) || (rerr[i] !== e_err) || (rdat[i] !== e_rdata) ||
                  (e_ren && raddr[i] !== e_waddr) ||
                  (e_wen && (waddr[i] !== e_waddr || wdat[i] !== e_wdata));
            checks = checks + 1;
            if (bad) begin
                errors = errors + 1;
                $display("FAIL model_cycle inst%0d t=%0t: got rdy=%b ren=%b ra=%h wen=%b wa=%h wd=%h rv=%b rd=%h err=%b; expected rdy=%b ren=%b ra=%h wen=%b wd=%h rv=%b rd=%h err=%b",
                         i, $time, ready[i], ren[i], raddr[i], wen[i], waddr[i], wdat[i], rvalid[i], rdat[i], rerr[i],
                         e_rdy, e_ren, e_waddr, e_wen, e_wdata, e_rv, e_rdata, e_err);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = idx;
        poke_val = val;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    logic [31:0] r_data, r_raddr, r_wdata;
    logic        r_err;
    int          r_cyc, r_rdcyc, r_wrcyc;

    task automatic do_req(input bit s, input bit we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        sel = s; req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
        r_cyc = 0; r_rdcyc = 0; r_wrcyc = 0;
        r_data = 32'hX; r_err = 1'bX; r_raddr = 32'h0; r_wdata = 32'h0;
        for (int n = 1; n <= 20 && r_cyc == 0; n++) begin
            @(negedge clk);
            if (ren[s]) begin r_rdcyc = n; r_raddr = raddr[s]; end
            if (wen[s]) begin r_wrcyc = n; r_wdata = wdat[s]; end
            if (rvalid[s]) begin r_cyc = n; r_data = rdat[s]; r_err = rerr[s]; end
        end
        if (r_cyc == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL resp_timeout: got no resp_valid within 20 cycles, expected one");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit seen_w;
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", {30'h0, ready}, 32'h3);
        chk("rst_outs", {24'h0, ren, wen, rvalid, rerr}, 32'h0);
        chk("rst_rdata", rdat[0] | rdat[1], 32'h0);
        poke(8'd64, 32'h80FF_1234);
        @(negedge clk) rst = 1'b0;

        do_req(0, 0, 3'b000, 32'h103, 32'h0);
        chk("lb_rdata", r_data, 32'hFFFF_FF80);
        chk("lb_err", {31'h0, r_err}, 32'h0);
        chk("lb_cyc", r_cyc, 2);
        chk("lb_rdcyc", r_rdcyc, 1);
        chk("lb_raddr", r_raddr, 32'h100);
        do_req(0, 0, 3'b101, 32'h102, 32'h0);
        chk("lhu_rdata", r_data, 32'h0000_80FF);
        do_req(0, 0, 3'b001, 32'h102, 32'h0);
        chk("lh_neg", r_data, 32'hFFFF_80FF);
        do_req(0, 0, 3'b001, 32'h100, 32'h0);
        chk("lh_pos", r_data, 32'h0000_1234);
        do_req(0, 0, 3'b000, 32'h101, 32'h0);
        chk("lb_pos", r_data, 32'h0000_0012);
        do_req(0, 0, 3'b100, 32'h103, 32'h0);
        chk("lbu", r_data, 32'h0000_0080);
        do_req(0, 0, 3'b010, 32'h100, 32'h0);
        chk("lw", r_data, 32'h80FF_1234);

        poke(8'd64, 32'h1122_3344);
        do_req(0, 1, 3'b000, 32'h101, 32'hFFFF_FFAB);
        chk("sb_rdcyc", r_rdcyc, 1);
        chk("sb_wrcyc", r_wrcyc, 2);
        chk("sb_wdata", r_wdata, 32'h1122_AB44);
        chk("sb_cyc", r_cyc, 3);
        chk("sb_rdata", r_data, 32'h0);
        chk("sb_mem", mem[64], 32'h1122_AB44);
        do_req(0, 1, 3'b001, 32'h102, 32'h0000_BEEF);
        chk("sh_wdata", r_wdata, 32'hBEEF_AB44);
        chk("sh_cyc", r_cyc, 3);

        do_req(0, 1, 3'b010, 32'h2, 32'h1);
        chk("sw_mis_cyc", r_cyc, 1);
        chk("sw_mis_err", {31'h0, r_err}, 32'h1);
        chk("sw_mis_mem", r_rdcyc + r_wrcyc, 0);
        do_req(0, 0, 3'b001, 32'h101, 32'h0);
        chk("lh_mis_err", {31'h0, r_err}, 32'h1);
        do_req(0, 0, 3'b011, 32'h100, 32'h0);
        chk("ld_f3_err", {31'h0, r_err}, 32'h1);
        do_req(0, 1, 3'b100, 32'h100, 32'h0);
        chk("st_f3_err", {31'h0, r_err}, 32'h1);
        chk("st_f3_mem", r_rdcyc + r_wrcyc, 0);
        do_req(0, 0, 3'b010, 32'h102, 32'h0);
        chk("lw_mis_rdata", r_data, 32'h0);

        do_req(0, 1, 3'b010, 32'h104, 32'hCAFE_F00D);
        chk("sw_wrcyc", r_wrcyc, 1);
        chk("sw_cyc", r_cyc, 2);
        chk("sw_wdata", r_wdata, 32'hCAFE_F00D);
        chk("sw_mem", mem[65], 32'hCAFE_F00D);

        poke(8'd128, 32'hDEAD_BEEF);
        do_req(1, 1, 3'b001, 32'h200, 32'h0000_5555);
        chk("sh3_rdcyc", r_rdcyc, 1);
        chk("sh3_wrcyc", r_wrcyc, 4);
        chk("sh3_wdata", r_wdata, 32'hDEAD_5555);
        chk("sh3_cyc", r_cyc, 5);
        do_req(1, 0, 3'b000, 32'h203, 32'h0);
        chk("lb3_rdata", r_data, 32'hFFFF_FFDE);
        chk("lb3_cyc", r_cyc, 4);
        do_req(1, 0, 3'b101, 32'h202, 32'h0);
        chk("lhu3_rdata", r_data, 32'h0000_DEAD);

        @(negedge clk);
        sel = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h201; req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ready", {31'h0, ready[1]}, 32'h1);
        chk("midrst_outs", {28'h0, ren[1], wen[1], rvalid[1], rerr[1]}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        seen_w = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (wen[1]) seen_w = 1'b1;
        end
        chk("midrst_no_wr", {31'h0, seen_w}, 32'h0);
        chk("midrst_mem", mem[128], 32'hDEAD_5555);
        do_req(1, 0, 3'b010, 32'h200, 32'h0);
        chk("post_rst_lw", r_data, 32'hDEAD_5555);
        chk("post_rst_cyc", r_cyc, 4);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
